// File: rtl/uart_ctrl_pkg.sv
// Shared state encodings and constants for the UART host-side sequencer.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_ARB  = 2'd1,
        T_XFER = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_HOLD = 2'd2
    } rx_state_e;

    localparam int TXBEGIN_IDLE_CYC = 2;
    localparam int STAT_W           = 16;

endpackage

// File: rtl/uart_host_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = (int'(ptr) + off) % NREQ;
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_host_ctrl.sv
// Host-side UART sequencer: bursts requester bytes into the TX FIFO and drains the RX FIFO.
// Optional byte counters are built when UART_CTRL_STATS_EN is defined.
module uart_host_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4,
    parameter int RX_RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        gnt,
    output logic                   tx_wen,
    output logic [DATA_W-1:0]      tx_write_data,
    input  logic                   tx_full,
    input  logic                   tx_empty,
    input  logic                   tx_done,
    output logic                   tx_begin,
    output logic                   rx_ren,
    input  logic [DATA_W-1:0]      rx_read_data,
    input  logic                   rx_empty,
    output logic                   rx_out_valid,
    output logic [DATA_W-1:0]      rx_out_data,
    input  logic                   rx_out_ready,
`ifdef UART_CTRL_STATS_EN
    output logic [STAT_W-1:0]      tx_byte_cnt,
    output logic [STAT_W-1:0]      rx_byte_cnt,
`endif
    output logic                   busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 4;
    localparam int IC_W  = 2;
    localparam int LAT_W = 2;

    tx_state_e        tx_state;
    rx_state_e        rx_state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic [CNT_W-1:0] burst_cnt;
    logic [IC_W-1:0]  idle_cnt;
    logic [LAT_W-1:0] wait_cnt;

    logic [NREQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic              accept;
    logic              burst_hit;
    logic              xfer_exit;
    logic              tx_idle_q;
    logic              rx_hs;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        g_valid       = req_valid[gidx];
        g_last        = req_last[gidx];
        g_data        = req_data[int'(gidx)*DATA_W +: DATA_W];
        accept        = (tx_state == T_XFER) && g_valid && !tx_full;
        req_ready     = accept ? gnt : '0;
        tx_wen        = accept;
        tx_write_data = accept ? g_data : '0;
        burst_hit     = (burst_cnt == CNT_W'(BURST_MAX - 1));
        // A stalled-but-valid requester keeps its grant; only a dropped valid ends the burst early.
        xfer_exit     = accept ? (g_last || burst_hit) : !g_valid;
        tx_idle_q     = (tx_state == T_IDLE) && tx_empty && tx_done;
        busy          = (tx_state != T_IDLE) || tx_begin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= T_IDLE;
            gnt       <= '0;
            gidx      <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            tx_begin  <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (|req_valid) tx_state <= T_ARB;
                end
                T_ARB: begin
                    if (arb_any) begin
                        gnt      <= arb_gnt;
                        gidx     <= arb_idx;
                        tx_state <= T_XFER;
                    end else begin
                        tx_state <= T_IDLE;
                    end
                end
                T_XFER: begin
                    if (xfer_exit) begin
                        ptr       <= (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
                        burst_cnt <= '0;
                        gnt       <= '0;
                        tx_state  <= T_ARB;
                    end else if (accept) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase

            if (!tx_idle_q)
                idle_cnt <= '0;
            else if (idle_cnt < IC_W'(TXBEGIN_IDLE_CYC - 1))
                idle_cnt <= idle_cnt + 1'b1;

            if (accept)
                tx_begin <= 1'b1;
            else if (tx_idle_q && idle_cnt >= IC_W'(TXBEGIN_IDLE_CYC - 1))
                tx_begin <= 1'b0;
        end
    end

    // Read strobe is combinational so a consumed byte can be replaced back-to-back.
    always_comb begin
        rx_hs  = rx_out_valid && rx_out_ready;
        rx_ren = !rst && !rx_empty &&
                 ((rx_state == R_IDLE) || ((rx_state == R_HOLD) && rx_hs));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= R_IDLE;
            rx_out_valid <= 1'b0;
            rx_out_data  <= '0;
            wait_cnt     <= '0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    if (!rx_empty) begin
                        wait_cnt <= '0;
                        rx_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (wait_cnt == LAT_W'(RX_RD_LAT - 1)) begin
                        rx_out_data  <= rx_read_data;
                        rx_out_valid <= 1'b1;
                        rx_state     <= R_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                R_HOLD: begin
                    if (rx_hs) begin
                        rx_out_valid <= 1'b0;
                        wait_cnt     <= '0;
                        rx_state     <= rx_empty ? R_IDLE : R_WAIT;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

`ifdef UART_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_byte_cnt <= '0;
            rx_byte_cnt <= '0;
        end else begin
            if (accept) tx_byte_cnt <= tx_byte_cnt + 1'b1;
            if (rx_hs)  rx_byte_cnt <= rx_byte_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Self-checking bench for uart_host_ctrl: requester/FIFO models with scoreboards.
module tb_uart_host_ctrl;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   gnt;
    logic              tx_wen;
    logic [DW-1:0]     tx_write_data;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_done;
    logic              tx_begin;
    logic              rx_ren;
    logic [DW-1:0]     rx_read_data;
    logic              rx_empty;
    logic              rx_out_valid;
    logic [DW-1:0]     rx_out_data;
    logic              rx_out_ready;
    logic              busy;
`ifdef UART_CTRL_STATS_EN
    logic [15:0]       tx_byte_cnt;
    logic [15:0]       rx_byte_cnt;
`endif

    uart_host_ctrl #(.NREQ(NREQ), .DATA_W(DW), .BURST_MAX(4), .RX_RD_LAT(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .gnt           (gnt),
        .tx_wen        (tx_wen),
        .tx_write_data (tx_write_data),
        .tx_full       (tx_full),
        .tx_empty      (tx_empty),
        .tx_done       (tx_done),
        .tx_begin      (tx_begin),
        .rx_ren        (rx_ren),
        .rx_read_data  (rx_read_data),
        .rx_empty      (rx_empty),
        .rx_out_valid  (rx_out_valid),
        .rx_out_data   (rx_out_data),
        .rx_out_ready  (rx_out_ready),
`ifdef UART_CTRL_STATS_EN
        .tx_byte_cnt   (tx_byte_cnt),
        .rx_byte_cnt   (rx_byte_cnt),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        int         len;
        logic [7:0] base;
    } tx_vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    logic [8:0] req_q [NREQ][$];
    logic [7:0] sb_q  [NREQ][$];
    logic [7:0] rx_fifo[$];
    logic [7:0] rx_sb[$];
    int         wr_log[$];

    logic [NREQ-1:0] s_gnt, s_ready;
    logic            s_wen, s_txb, s_busy, s_ren, s_rv;
    logic [7:0]      s_data, s_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += req_q[i].size();
        return n;
    endfunction

    function automatic int sb_pending();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += sb_q[i].size();
        return n;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (req_q[i].size() > 0);
            req_data[i*DW +: DW] = (req_q[i].size() > 0) ? req_q[i][0][7:0] : 8'h00;
            req_last[i]  = (req_q[i].size() > 0) ? req_q[i][0][8] : 1'b0;
        end
        rx_empty = (rx_fifo.size() == 0);
    endtask

    task automatic enq(input int r, input logic [7:0] d, input logic last);
        req_q[r].push_back({last, d});
        sb_q[r].push_back(d);
    endtask

    task automatic flush();
        for (int i = 0; i < NREQ; i++) begin
            req_q[i].delete();
            sb_q[i].delete();
        end
        rx_fifo.delete();
        rx_sb.delete();
        wr_log.delete();
    endtask

    task automatic tick();
        int g;
        logic [7:0] e;
        @(negedge clk);
        s_wen   = tx_wen;   s_data = tx_write_data; s_gnt = gnt; s_ready = req_ready;
        s_txb   = tx_begin; s_busy = busy;          s_ren = rx_ren;
        s_rv    = rx_out_valid; s_rd = rx_out_data;
        chk("ready_vs_gnt", 32'(s_ready), s_wen ? 32'(s_gnt) : 32'd0);
        if (tx_full) chk("wen_while_full", 32'(s_wen), 32'd0);
        if (s_wen) begin
            g = 0;
            for (int i = 0; i < NREQ; i++) if (s_gnt[i]) g = i;
            chk("gnt_onehot", 32'($onehot(s_gnt)), 32'd1);
            wr_log.push_back(g);
            if (sb_q[g].size() == 0) chk("tx_unexpected", 32'(sb_q[g].size()), 32'd1);
            else begin
                e = sb_q[g].pop_front();
                chk("tx_data", 32'(s_data), 32'(e));
            end
        end
        if (s_rv && rx_out_ready) begin
            if (rx_sb.size() == 0) chk("rx_unexpected", 32'(rx_sb.size()), 32'd1);
            else begin
                e = rx_sb.pop_front();
                chk("rx_data", 32'(s_rd), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (s_ready[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        if (s_ren) begin
            if (rx_fifo.size() > 0) rx_read_data = rx_fifo.pop_front();
            else chk("rx_ren_on_empty", 32'(rx_fifo.size()), 32'd1);
        end
        drive();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (pending() > 0 && k < budget) begin
            tick();
            k++;
        end
        chk("drain_timeout", 32'(pending()), 32'd0);
        repeat (4) tick();
        chk("tx_sb_left", 32'(sb_pending()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush();
        drive();
        #1;
        chk("reset_outputs",
            {3'b0, gnt, req_ready, tx_wen, tx_write_data, tx_begin, rx_ren, rx_out_valid, rx_out_data, busy},
            32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    tx_vec_t tbl[4];
    logic    exp_wen[5];
    logic    exp_ren[5];
    logic    exp_rv[5];
    int      bad;
    int      k;

    initial begin
        tbl[0] = '{idx: 2, len: 3, base: 8'h40};
        tbl[1] = '{idx: 3, len: 1, base: 8'h50};
        tbl[2] = '{idx: 0, len: 2, base: 8'h60};
        tbl[3] = '{idx: 1, len: 4, base: 8'h70};
        exp_wen = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_ren = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_rv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        req_valid = '0; req_data = '0; req_last = '0;
        tx_full = 1'b0; tx_empty = 1'b1; tx_done = 1'b1;
        rx_read_data = '0; rx_empty = 1'b1; rx_out_ready = 1'b1;
        do_reset();

        // Single 3-byte message from requester 0; watch arbitration latency and tx_begin.
        enq(0, 8'h11, 1'b0); enq(0, 8'h22, 1'b0); enq(0, 8'h33, 1'b1);
        tx_empty = 1'b0; tx_done = 1'b0;
        drive();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("msg_wen_c%0d", c), 32'(s_wen), 32'(exp_wen[c]));
            if (c == 2) begin
                chk("msg_gnt", 32'(s_gnt), 32'd1);
                chk("txb_before_first", 32'(s_txb), 32'd0);
            end
            if (c == 3) chk("txb_after_first", 32'(s_txb), 32'd1);
        end
        tx_empty = 1'b1; tx_done = 1'b1;
        for (int c = 5; c < 9; c++) begin
            tick();
            chk($sformatf("txb_c%0d", c), 32'(s_txb), (c < 8) ? 32'd1 : 32'd0);
        end
        chk("busy_after_idle", 32'(s_busy), 32'd0);

        // Pointer advanced past requester 0, so requester 1 wins the tie.
        wr_log.delete();
        enq(0, 8'h81, 1'b1); enq(1, 8'h91, 1'b1);
        drive();
        drain(20);
        chk("ptr_order_n", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            chk("ptr_first", 32'(wr_log[0]), 32'd1);
            chk("ptr_second", 32'(wr_log[1]), 32'd0);
        end

        // Two continuously valid requesters alternate in bursts of BURST_MAX.
        do_reset();
        for (int b = 0; b < 8; b++) begin
            enq(0, 8'h00 + 8'(b), 1'b0);
            enq(2, 8'h20 + 8'(b), 1'b0);
        end
        drive();
        drain(100);
        chk("burst_total", 32'(wr_log.size()), 32'd16);
        for (int w = 0; w < wr_log.size() && w < 16; w++)
            chk($sformatf("burst_gidx_%0d", w), 32'(wr_log[w]), ((w / 4) % 2 == 0) ? 32'd0 : 32'd2);

        // TX FIFO full after the second byte of a burst: stall with grant held.
        wr_log.delete();
        for (int b = 0; b < 4; b++) enq(1, 8'hC0 + 8'(b), b == 3);
        drive();
        k = 0;
        while (wr_log.size() < 2 && k < 20) begin
            tick();
            k++;
        end
        chk("stall_reach", 32'(wr_log.size()), 32'd2);
        tx_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_ready", 32'(s_ready), 32'd0);
            chk("stall_wen", 32'(s_wen), 32'd0);
            chk("stall_gnt", 32'(s_gnt), 32'b0010);
        end
        tx_full = 1'b0;
        drain(20);
        chk("stall_total", 32'(wr_log.size()), 32'd4);

        // Table of single-requester messages.
        foreach (tbl[v]) begin
            wr_log.delete();
            for (int b = 0; b < tbl[v].len; b++)
                enq(tbl[v].idx, tbl[v].base + 8'(b), b == tbl[v].len - 1);
            drive();
            drain(40);
            chk($sformatf("tbl%0d_len", v), 32'(wr_log.size()), 32'(tbl[v].len));
            bad = 0;
            foreach (wr_log[w]) if (wr_log[w] != tbl[v].idx) bad++;
            chk($sformatf("tbl%0d_gnt", v), 32'(bad), 32'd0);
        end

        // RX drain with consumer always ready.
        rx_out_ready = 1'b1;
        rx_fifo.push_back(8'hA5); rx_sb.push_back(8'hA5);
        rx_fifo.push_back(8'h3C); rx_sb.push_back(8'h3C);
        drive();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("rx_ren_c%0d", c), 32'(s_ren), 32'(exp_ren[c]));
            chk($sformatf("rx_valid_c%0d", c), 32'(s_rv), 32'(exp_rv[c]));
        end
        chk("rx_sb_left", 32'(rx_sb.size()), 32'd0);

        // RX with consumer stalled: only one read until the handshake.
        rx_out_ready = 1'b0;
        rx_fifo.push_back(8'h01); rx_sb.push_back(8'h01);
        rx_fifo.push_back(8'h02); rx_sb.push_back(8'h02);
        drive();
        tick();
        chk("rx_hold_first_ren", 32'(s_ren), 32'd1);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (s_ren) bad++;
        end
        chk("rx_hold_extra_ren", 32'(bad), 32'd0);
        chk("rx_hold_valid", 32'(s_rv), 32'd1);
        chk("rx_hold_data", 32'(s_rd), 32'h01);
        rx_out_ready = 1'b1;
        k = 0;
        while (rx_sb.size() > 0 && k < 10) begin
            tick();
            k++;
        end
        chk("rx_hold_drain", 32'(rx_sb.size()), 32'd0);

        // Asynchronous reset in the middle of a burst.
        wr_log.delete();
        for (int b = 0; b < 4; b++) enq(2, 8'hD0 + 8'(b), b == 3);
        drive();
        k = 0;
        while (wr_log.size() < 1 && k < 20) begin
            tick();
            k++;
        end
        chk("mid_reach", 32'(wr_log.size()), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs",
            {3'b0, gnt, req_ready, tx_wen, tx_write_data, tx_begin, rx_ren, rx_out_valid, rx_out_data, busy},
            32'd0);
        flush();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        enq(0, 8'hE0, 1'b1); enq(3, 8'hF0, 1'b1);
        drive();
        drain(20);
        chk("post_rst_n", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() > 0) chk("post_rst_first", 32'(wr_log[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t required finish earlier", $time);
        $fatal(1);
    end

endmodule
